// File: rtl/hb_pkg.sv
// Shared halfband definitions: widths, 27-tap prototype coefficients, saturation and FSM states.
package hb_pkg;

  localparam int DATA_W = 16;
  localparam int ACC_W  = 38;
  localparam int NTAP   = 14;
  localparam int NCOEF  = 7;

  // Outer-to-centre non-zero taps of the symmetric halfband prototype (Q15).
  localparam logic signed [DATA_W-1:0] W_HB [0:NCOEF-1] = '{
    16'sd1, -16'sd10, 16'sd64, -16'sd275, 16'sd897, -16'sd2577, 16'sd10091
  };

  localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = ACC_W'(-32768);
  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(8192);

  typedef enum logic [1:0] {IDLE, CALC, OUT_A, OUT_B} hb_state_e;

  function automatic logic signed [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
    logic signed [DATA_W-1:0] r;
    if (v > SAT_MAX)      r = 16'sh7FFF;
    else if (v < SAT_MIN) r = 16'sh8000;
    else                  r = v[DATA_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/hb_mac7.sv
// Three-stage pair-sum / multiply / accumulate datapath over a 14-deep symmetric delay line.
module hb_mac7
  import hb_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start_i,
  input  logic signed [DATA_W-1:0] taps_i [NTAP],
  output logic signed [ACC_W-1:0]  acc_o,
  output logic                     acc_valid_o
);

  logic signed [DATA_W:0]   pair_q [NCOEF];
  logic signed [2*DATA_W:0] prod_q [NCOEF];
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     pairVld_q, prodVld_q, accValid_q;

  always_comb begin
    acc_d = '0;
    for (int j = 0; j < NCOEF; j++) acc_d = acc_d + ACC_W'(prod_q[j]);
  end

  // acc_q holds its result until the next start so the output stage can stall on it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j < NCOEF; j++) begin
        pair_q[j] <= '0;
        prod_q[j] <= '0;
      end
      acc_q      <= '0;
      pairVld_q  <= 1'b0;
      prodVld_q  <= 1'b0;
      accValid_q <= 1'b0;
    end else begin
      pairVld_q <= start_i;
      prodVld_q <= pairVld_q;
      if (start_i) begin
        for (int j = 0; j < NCOEF; j++)
          pair_q[j] <= {taps_i[j][DATA_W-1], taps_i[j]}
                     + {taps_i[NTAP-1-j][DATA_W-1], taps_i[NTAP-1-j]};
      end
      if (pairVld_q) begin
        for (int j = 0; j < NCOEF; j++)
          prod_q[j] <= (2*DATA_W+1)'(pair_q[j]) * (2*DATA_W+1)'(W_HB[j]);
      end
      if (prodVld_q) acc_q <= acc_d;
      if (start_i)        accValid_q <= 1'b0;
      else if (prodVld_q) accValid_q <= 1'b1;
    end
  end

  assign acc_o       = acc_q;
  assign acc_valid_o = accValid_q;

endmodule

// File: rtl/hb_interp2.sv
// Halfband interpolate-by-2: each accepted input yields a filtered phase A then the centre tap as phase B.
// Define HB_INTERP_ROUND_EN for round-half-up on phase A instead of floor truncation.
module hb_interp2
  import hb_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic                     x_in_valid,
  output logic                     x_in_ready,
  output logic signed [DATA_W-1:0] y_out,
  output logic                     y_out_valid,
  input  logic                     y_out_ready
);

  hb_state_e                state_q, state_d;
  logic [1:0]               cnt_q, cnt_d;
  logic signed [DATA_W-1:0] d_q [NTAP];
  logic                     macStart, accValid, accept;
  logic signed [ACC_W-1:0]  acc, accAdj, accShr;
  logic signed [DATA_W-1:0] phaseA;

  hb_mac7 u_mac (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_i     (macStart),
    .taps_i      (d_q),
    .acc_o       (acc),
    .acc_valid_o (accValid)
  );

`ifdef HB_INTERP_ROUND_EN
  assign accAdj = acc + RND_HALF;
`else
  assign accAdj = acc;
`endif
  assign accShr = accAdj >>> 14;
  assign phaseA = sat16(accShr);

  assign accept = x_in_valid && x_in_ready;
  assign y_out  = (state_q == OUT_B) ? d_q[6] : phaseA;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_in_ready  = 1'b0;
    y_out_valid = 1'b0;
    macStart    = 1'b0;
    case (state_q)
      IDLE: begin
        x_in_ready = 1'b1;
        if (x_in_valid) begin
          state_d = CALC;
          cnt_d   = 2'd0;
        end
      end
      CALC: begin
        macStart = (cnt_q == 2'd0);
        cnt_d    = cnt_q + 2'd1;
        if (cnt_q == 2'd2) state_d = OUT_A;
      end
      OUT_A: begin
        y_out_valid = accValid;
        if (accValid && y_out_ready) state_d = OUT_B;
      end
      OUT_B: begin
        y_out_valid = 1'b1;
        if (y_out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The delay line only moves on an accepted sample, so d_q[6] stays valid for phase B.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      for (int k = 0; k < NTAP; k++) d_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        for (int k = NTAP-1; k > 0; k--) d_q[k] <= d_q[k-1];
        d_q[0] <= x_in;
      end
    end
  end

endmodule
